// File: rtl/piso_pkg.sv
// piso_pkg: shared sizing and length-normalisation helpers for the PISO serialisers
package piso_pkg;
    function automatic int cnt_width(int dw);
        return $clog2(dw + 1);
    endfunction
    function automatic int norm_len(int len, int dw);
        return (len == 0 || len > dw) ? dw : len;
    endfunction
endpackage

// File: rtl/piso_hold_buf.sv
// piso_hold_buf: one-entry registered holding buffer, valid/ready in, load strobe out
module piso_hold_buf #(
    parameter type T = logic
) (
    input  logic clk,
    input  logic rst,
    input  T     data_i,
    input  logic valid_i,
    output logic ready_o,
    input  logic free_i,
    output logic load_o,
    output T     data_o,
    output logic vld_o
);
    logic vld_q, vld_d, rdy_q, accept;
    T     data_q;
    assign accept  = valid_i && rdy_q;
    assign load_o  = vld_q && free_i;
    assign vld_d   = accept ? 1'b1 : load_o ? 1'b0 : vld_q;
    assign ready_o = rdy_q;
    assign data_o  = data_q;
    assign vld_o   = vld_q;
    // ready is its own register so it stays low throughout reset
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= 1'b0;
            rdy_q  <= 1'b0;
            data_q <= '0;
        end else begin
            vld_q <= vld_d;
            rdy_q <= !vld_d;
            if (accept) data_q <= data_i;
        end
    end
endmodule

// File: rtl/piso_stream.sv
// piso_stream: streaming parallel-in serial-out serialiser with per-word length and framing
module piso_stream import piso_pkg::*; #(
    parameter int DATA_WIDTH = 8,
    parameter bit MSB_FIRST  = 1'b0,
    parameter int CNT_W      = cnt_width(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CNT_W-1:0]      in_len,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_first,
    output logic                  out_last,
    output logic                  busy
);
    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [CNT_W-1:0]      len;
    } word_t;
    word_t                 in_word, hold_word;
    logic [DATA_WIDTH-1:0] sh_q, sh_d;
    logic [CNT_W-1:0]      rem_q, rem_d;
    logic                  first_q, first_d, consume, free, load, hold_vld;
    assign in_word = '{data: in_data, len: CNT_W'(norm_len(int'(in_len), DATA_WIDTH))};
    piso_hold_buf #(.T(word_t)) u_hold (
        .clk     (clk),
        .rst     (rst),
        .data_i  (in_word),
        .valid_i (in_valid),
        .ready_o (in_ready),
        .free_i  (free),
        .load_o  (load),
        .data_o  (hold_word),
        .vld_o   (hold_vld)
    );
    assign out_valid = rem_q != '0;
    assign consume   = out_valid && out_ready;
    // the shifter may reload on the same edge that its last bit leaves
    assign free      = rem_q == '0 || (consume && rem_q == CNT_W'(1));
    assign out_data  = out_valid && (MSB_FIRST ? sh_q[DATA_WIDTH-1] : sh_q[0]);
    assign out_first = out_valid && first_q;
    assign out_last  = out_valid && rem_q == CNT_W'(1);
    assign busy      = out_valid || hold_vld;
    always_comb begin
        sh_d    = sh_q;
        rem_d   = rem_q;
        first_d = first_q;
        if (load) begin
            sh_d    = MSB_FIRST ? hold_word.data << (DATA_WIDTH - int'(hold_word.len)) : hold_word.data;
            rem_d   = hold_word.len;
            first_d = 1'b1;
        end else if (consume) begin
            sh_d    = MSB_FIRST ? sh_q << 1 : sh_q >> 1;
            rem_d   = rem_q - CNT_W'(1);
            first_d = 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q    <= '0;
            rem_q   <= '0;
            first_q <= 1'b0;
        end else begin
            sh_q    <= sh_d;
            rem_q   <= rem_d;
            first_q <= first_d;
        end
    end
endmodule

// File: tb/tb_piso_stream.sv
// tb_piso_stream: scoreboard bench running LSB-first and MSB-first instances side by side
module tb_piso_stream;
    localparam int DW = 8;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = '0;
    logic [3:0] in_len = '0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       l_ready, l_data, l_valid, l_first, l_last, l_busy;
    logic       m_ready, m_data, m_valid, m_first, m_last, m_busy;
    logic [7:0] cur, prev;
    logic [2:0] ql[$];
    logic [2:0] qm[$];
    int checks = 0, errors = 0, pops = 0, vcnt = 0, gaps = 0, cyc = 0, lv = 0, last_acc = 0;
    logic stall = 1'b0, prev_v = 1'b0;

    piso_stream #(.DATA_WIDTH(DW), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_len(in_len), .in_valid(in_valid),
        .in_ready(l_ready), .out_data(l_data), .out_valid(l_valid), .out_ready(out_ready),
        .out_first(l_first), .out_last(l_last), .busy(l_busy));
    piso_stream #(.DATA_WIDTH(DW), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_len(in_len), .in_valid(in_valid),
        .in_ready(m_ready), .out_data(m_data), .out_valid(m_valid), .out_ready(out_ready),
        .out_first(m_first), .out_last(m_last), .busy(m_busy));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    assign cur = {l_valid, l_data, l_first, l_last, m_valid, m_data, m_first, m_last};

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // monitor: pops expected bits, checks stall stability and gathers gap statistics
    always @(negedge clk) begin
        if (rst) begin
            stall = 1'b0;
            prev_v = 1'b0;
        end else begin
            if (stall) chk("stall_hold", cur, prev);
            stall = l_valid && !out_ready;
            prev = cur;
            if (l_valid) begin
                vcnt++;
                lv = cyc;
            end else if (l_busy && prev_v) gaps++;
            prev_v = l_valid;
            if (l_valid && out_ready) begin
                pops++;
                if (ql.size() == 0) chk("lsb_unexpected_bit", ql.size(), 1);
                else chk("lsb_bit", {l_data, l_first, l_last}, ql.pop_front());
            end
            if (m_valid && out_ready) begin
                if (qm.size() == 0) chk("msb_unexpected_bit", qm.size(), 1);
                else chk("msb_bit", {m_data, m_first, m_last}, qm.pop_front());
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic [3:0] l);
        int n = 0;
        int len;
        in_data = d;
        in_len = l;
        in_valid = 1'b1;
        while (n < 200) begin
            @(negedge clk);
            if (l_ready) break;
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready 0 expected 1");
        end
        @(posedge clk);
        if (n < 200) begin
            len = (l == 0 || l > DW) ? DW : int'(l);
            for (int i = 0; i < len; i++) begin
                ql.push_back({d[i], i == 0, i == len - 1});
                qm.push_back({d[len-1-i], i == 0, i == len - 1});
            end
        end
        #1;
        last_acc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (n < 500) begin
            @(negedge clk);
            if (!l_busy && !m_busy) break;
            n++;
        end
        if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy 1 expected 0");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pops(input int target);
        int n = 0;
        while (pops < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (pops < target) begin
            checks++;
            errors++;
            $display("FAIL pop_timeout: got %0d expected %0d", pops, target);
        end
    endtask

    initial begin
        int v0, g0, a1, p0;
        bit done;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {l_ready, l_valid, l_data, l_first, l_last, l_busy,
                              m_ready, m_valid, m_data, m_first, m_last, m_busy}, 0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_reset", {l_ready, m_ready, l_valid, l_busy}, 4'b1100);
        @(posedge clk);
        #1;
        // latency and basic framing
        out_ready = 1'b1;
        send(8'hA5, 4'd8);
        @(negedge clk);
        chk("latency_hold", {l_valid, l_ready, l_busy}, 3'b001);
        @(negedge clk);
        chk("latency_first", {l_valid, l_ready, l_first}, 3'b111);
        @(posedge clk);
        #1;
        wait_idle();
        send(8'h0D, 4'd4);
        wait_idle();
        // back-to-back words with no bubble
        v0 = vcnt;
        g0 = gaps;
        send(8'hFF, 4'd8);
        a1 = last_acc;
        send(8'h00, 4'd3);
        wait_idle();
        chk("b2b_valid_count", vcnt - v0, 11);
        chk("b2b_gaps", gaps - g0, 0);
        chk("b2b_span", lv - a1, 11);
        // backpressure mid-word
        p0 = pops;
        send(8'h3C, 4'd8);
        wait_pops(p0 + 2);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_idle();
        // length edge cases
        send(8'h96, 4'd0);
        wait_idle();
        send(8'h5A, 4'd12);
        wait_idle();
        send(8'hFE, 4'd1);
        wait_idle();
        v0 = vcnt;
        g0 = gaps;
        send(8'h01, 4'd1);
        a1 = last_acc;
        send(8'h00, 4'd1);
        send(8'h01, 4'd1);
        send(8'hFF, 4'd1);
        wait_idle();
        chk("len1_valid_count", vcnt - v0, 4);
        chk("len1_gaps", gaps - g0, 3);
        chk("len1_span", lv - a1, 7);
        // reset mid-word with a second word held
        p0 = pops;
        send(8'hC3, 4'd8);
        send(8'h55, 4'd8);
        wait_pops(p0 + 3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        ql.delete();
        qm.delete();
        @(posedge clk);
        #1;
        chk("midword_reset_outputs", {l_ready, l_valid, l_data, l_first, l_last, l_busy,
                                      m_ready, m_valid, m_data, m_first, m_last, m_busy}, 0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("after_midword_reset", {l_ready, l_valid, l_busy, m_ready, m_valid, m_busy}, 6'b100100);
        @(posedge clk);
        #1;
        send(8'h81, 4'd8);
        wait_idle();
        // randomized traffic with random backpressure
        done = 1'b0;
        fork
            begin
                repeat (150) begin
                    send(8'($urandom), 4'($urandom));
                    repeat ($urandom_range(0, 3)) begin
                        @(posedge clk);
                        #1;
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        wait_idle();
        chk("lsb_queue_drained", ql.size(), 0);
        chk("msb_queue_drained", qm.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/piso_stream.md
Name: piso_stream

Overview:
Parametrised parallel-in-serial-out serialiser, the successor to the current single-word PISO.
- Input side: valid/ready handshake, with a one-entry holding buffer so words stream back-to-back.
- Per-word length: programmable from 1 to DATA_WIDTH bits.
- Bit order: LSB-first or MSB-first, selected at build time.
- Output side: valid/ready handshake with first/last framing, feeding serial links (SPI-like TX, bit-banged line drivers) in the datapath.

Parameters:
DATA_WIDTH, 8, maximum bits per word (>=2).
MSB_FIRST, 0, 0 = send bit 0 first; 1 = send bit len-1 first.
CNT_W, $clog2(DATA_WIDTH+1), width of length/count fields (derived; do not override).

Ports:
clk  in  1  clock.
rst  in  1  synchronous, active-high reset.
in_data  in  DATA_WIDTH  parallel word.
in_len  in  CNT_W  bits to send; 0 or >DATA_WIDTH means DATA_WIDTH.
in_valid  in  1  in_data/in_len valid.
in_ready  out  1  holding buffer free; a word is accepted when in_valid && in_ready.
out_data  out  1  serial bit.
out_valid  out  1  out_data valid.
out_ready  in  1  downstream consumes the bit when out_valid && out_ready.
out_first  out  1  high with the first bit of a word.
out_last  out  1  high with the last bit of a word.
busy  out  1  out_valid || holding buffer occupied.

Behaviour:
- Reset (rst=1 at a clk edge): all state clears regardless of activity; any partial word is discarded.
  - Outputs while in reset: in_ready=0, out_valid=0, out_data=0, out_first=0, out_last=0, busy=0.
  - First cycle after reset: in_ready=1.
- Clock and reset: single clock domain, single always-edge. Reset is synchronous and active-high.
- Holding buffer (hold_vld, hold_data, hold_len):
  - in_ready = !hold_vld, registered, with no combinational path from out_ready.
  - Acceptance sets hold_vld. The word is stored with the length normalised (0 or >DATA_WIDTH becomes DATA_WIDTH).
- Shifter (sh, rem): load occurs when hold_vld && (rem==0 || (out_valid && out_ready && rem==1)).
  - On load: rem<=hold_len and hold_vld clears.
  - Load data for MSB_FIRST=0: sh<=hold_data.
  - Load data for MSB_FIRST=1: sh<=hold_data<<(DATA_WIDTH-len).
- Bit selection:
  - out_data = sh[0] for LSB-first, sh[DATA_WIDTH-1] for MSB-first.
  - Bits of in_data above len-1 are never transmitted.
- Output handshake and framing:
  - out_valid = (rem!=0).
  - On each bit consumed: sh shifts one place toward the output bit, and rem decrements.
  - out_first=1 while rem==loaded len and no bit of the word has yet been consumed. Track this with a first flag set on load and cleared on the first consume.
  - out_last = out_valid && rem==1.
  - With len=1, out_first and out_last are both high.
- Stall: while out_valid && !out_ready, out_data, out_first, out_last and rem hold stable (AXI-stream rule).
- Latency:
  - Accept at edge N: first bit is valid after edge N+1 when the shifter is idle.
  - Back-to-back words: zero bubble between the last bit of word k and the first bit of word k+1, provided word k+1 was accepted before word k's last bit was consumed.
- Throughput: one bit per cycle when out_ready=1 continuously and len>=2. For len=1 streams, a registered in_ready limits throughput to 1 word per 2 cycles; this is accepted.
- Simultaneous events: accept into hold and shifter load from hold in the same cycle cannot occur (in_ready=0 when hold_vld). A load and a consume in the same cycle are the zero-bubble path.
- Arithmetic: rem is CNT_W bits and is never decremented below 0. Shifts fill with zeros.

Decomposition:
- piso_pkg:
  - function norm_len(len, DATA_WIDTH).
  - localparam helper for CNT_W.
  - typedef struct packed {data, len} piso_word_t, shared by hold and shifter.
- Sub-module piso_hold_buf: one-entry registered buffer with a valid/ready in and load-strobe out, reusable for other serialisers.

Test Plan:
1. DATA_WIDTH=8, MSB_FIRST=0, out_ready=1; send 8'hA5 len=8 -> bits 1,0,1,0,0,1,0,1; first on bit 0, last on bit 7; in_ready high again 1 cycle after accept.
2. MSB_FIRST=1; send 8'h0D len=4 -> bits 1,1,0,1; the upper nibble is never sent; out_last with the 4th bit.
3. Back-to-back: words 8'hFF len=8 then 8'h00 len=3, out_ready=1 -> 11 consecutive valid cycles with no gap; out_last at cycles 8 and 11; out_first at cycles 1 and 9.
4. Backpressure: out_ready low for 5 cycles mid-word (after bit 2 of 8'h3C) -> out_data/out_first/out_last/rem frozen; resumes with bit 3 with no bit lost or duplicated.
5. Edge lengths: len=0 -> 8 bits sent; len=1 with 8'hFE -> single bit 0 with first=last=1; 4 len=1 words -> 1 word per 2 cycles.
6. Reset mid-word after 3 bits of 8'hC3, with a second word held -> next cycle out_valid=0, busy=0, in_ready=1; a new word 8'h81 then transmits cleanly from bit 0.
